// File: rtl/dot_pkg.sv
// -----------------------------------------------------------------------------
// dot_pkg
// Shared definitions for the dot-product chunk accumulator:
//   - default datapath widths and the latency of the hard sum-of-6 DSP chain
//   - sideband record carried alongside each chunk through the latency pipe
//   - default-width result record (accumulated sum + overflow flag)
//   - accumulator FSM state encoding
//   - signed-add overflow helper
// No ports (package).
// -----------------------------------------------------------------------------
package dot_pkg;

   localparam int DOT_PSUM_W     = 18;  // signed sum-of-6 from the DSP chain
   localparam int DOT_ACC_W      = 32;  // signed accumulator / result
   localparam int DOT6_LAT       = 4;   // DSP operand presentation -> psum valid
   localparam int DOT_FIFO_DEPTH = 4;   // result FIFO entries

   // Per-chunk sideband, delayed to line up with the DSP output.
   typedef struct packed {
      logic v;   // chunk valid
      logic f;   // first chunk of a vector
      logic l;   // last chunk of a vector
   } dot_sb_t;

   // Result record at the default accumulator width.
   typedef struct packed {
      logic signed [DOT_ACC_W-1:0] acc;
      logic                        ovf;
   } dot_res_t;

   typedef enum logic {
      ACC_IDLE = 1'b0,
      ACC_BUSY = 1'b1
   } acc_state_t;

   // Two's-complement add overflows when both operands share a sign and the
   // result sign differs from it.
   function automatic logic add_ovf(input logic a_sign,
                                    input logic b_sign,
                                    input logic r_sign);
      return (a_sign == b_sign) && (r_sign != a_sign);
   endfunction

endpackage

// File: rtl/dot_chunk_accumulator_if.sv
// -----------------------------------------------------------------------------
// dot_chunk_accumulator_if
// Bundles the issuer handshake, the DSP partial sum, the result valid/ready
// stream and the protocol-error flag of dot_chunk_accumulator.
//   issue_valid/first/last  issuer -> accumulator, chunk sideband
//   issue_ready             accumulator -> issuer, credit available
//   psum                    DSP chain -> accumulator, signed sum-of-6
//   out_valid/out_data/out_ovf  accumulator -> consumer, result FIFO head
//   out_ready               consumer -> accumulator
//   proto_err               accumulator -> system, sticky error flag
// Modports: master = issuer/DSP/consumer side, slave = the accumulator.
// -----------------------------------------------------------------------------
interface dot_chunk_accumulator_if
   import dot_pkg::*;
#(
   parameter int PSUM_W = DOT_PSUM_W,
   parameter int ACC_W  = DOT_ACC_W
);

   logic                     issue_valid;
   logic                     issue_first;
   logic                     issue_last;
   logic                     issue_ready;
   logic signed [PSUM_W-1:0] psum;
   logic                     out_valid;
   logic                     out_ready;
   logic signed [ACC_W-1:0]  out_data;
   logic                     out_ovf;
   logic                     proto_err;

   modport master (
      output issue_valid, issue_first, issue_last, psum, out_ready,
      input  issue_ready, out_valid, out_data, out_ovf, proto_err
   );

   modport slave (
      input  issue_valid, issue_first, issue_last, psum, out_ready,
      output issue_ready, out_valid, out_data, out_ovf, proto_err
   );

endinterface

// File: rtl/dot_result_fifo.sv
// -----------------------------------------------------------------------------
// dot_result_fifo
// Synchronous FIFO of packed result records with a registered head: the oldest
// entry always sits in r_head so o_dout comes straight from a flop. Entries
// behind the head live in a small memory. Push and pop may coincide at any
// occupancy, including full; a pop on empty is ignored, a push on full without
// a simultaneous pop is dropped.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   i_push       write i_din this cycle
//   i_din        record to write
//   i_pop        consumer takes the head (ignored while empty)
//   o_valid      head holds a valid record
//   o_dout       head record
//   o_count      number of stored records (0..DEPTH)
// -----------------------------------------------------------------------------
module dot_result_fifo #(
   parameter  int W     = 33,
   parameter  int DEPTH = 4,
   localparam int CNT_W = $clog2(DEPTH + 1)
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic [W-1:0]     i_din,
   input  logic             i_pop,
   output logic             o_valid,
   output logic [W-1:0]     o_dout,
   output logic [CNT_W-1:0] o_count
);

   localparam int ADDR_W = $clog2(DEPTH);

   logic [W-1:0]      r_mem [DEPTH];
   logic [W-1:0]      r_head;
   logic              r_head_v;
   logic [ADDR_W-1:0] r_wptr;
   logic [ADDR_W-1:0] r_rptr;
   logic [CNT_W-1:0]  r_cnt_t;     // records behind the head

   logic w_pop;
   logic w_full;
   logic w_push;
   logic w_from_mem;   // head refills from memory
   logic w_to_mem;     // incoming record queues behind the head
   logic w_to_head;    // incoming record lands directly in the head

   assign o_count    = r_cnt_t + CNT_W'(r_head_v);
   assign w_pop      = i_pop & r_head_v;
   assign w_full     = (o_count == CNT_W'(DEPTH));
   assign w_push     = i_push & (~w_full | w_pop);
   assign w_from_mem = w_pop & (r_cnt_t != '0);
   // With an empty memory a simultaneous pop frees the head for the new record.
   assign w_to_mem   = w_push & r_head_v & ~(w_pop & (r_cnt_t == '0));
   assign w_to_head  = w_push & ~w_to_mem;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_head   <= '0;
         r_head_v <= 1'b0;
         r_wptr   <= '0;
         r_rptr   <= '0;
         r_cnt_t  <= '0;
      end else begin
         // NOTE: state updates use <= so every flop samples pre-edge values regardless of statement order.
         if (w_from_mem) begin
            r_head <= r_mem[r_rptr];
         end else if (w_to_head) begin
            r_head <= i_din;
         end

         if (w_to_head) begin
            r_head_v <= 1'b1;
         end else if (w_pop && !w_from_mem) begin
            r_head_v <= 1'b0;
         end

         if (w_to_mem) begin
            r_wptr <= r_wptr + ADDR_W'(1);
         end
         if (w_from_mem) begin
            r_rptr <= r_rptr + ADDR_W'(1);
         end

         case ({w_to_mem, w_from_mem})
            2'b10:   r_cnt_t <= r_cnt_t + CNT_W'(1);
            2'b01:   r_cnt_t <= r_cnt_t - CNT_W'(1);
            default: r_cnt_t <= r_cnt_t;
         endcase
      end
   end

   // NOTE: storage behind the head has no reset; its contents are only read after being written, as tracked by r_cnt_t.
   always_ff @(posedge clk) begin
      if (w_to_mem) begin
         r_mem[r_wptr] <= i_din;
      end
   end

   assign o_valid = r_head_v;
   assign o_dout  = r_head;

endmodule

// File: rtl/dot_chunk_accumulator.sv
// -----------------------------------------------------------------------------
// dot_chunk_accumulator
// Sits directly behind the hard sum-of-6 DSP chain. Delays the issue-time
// sideband by the DSP latency so it lines up with psum, accumulates
// consecutive chunk sums into one dot product per vector, and queues results
// in a small FIFO. Because the DSP chain cannot stall, the issuer is throttled
// by credits: a reservation counter covers FIFO entries plus vectors whose
// last chunk is still in flight, so a push never finds the FIFO full.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   bus (slave)  issue_valid/first/last, issue_ready, psum,
//                out_valid/out_ready/out_data/out_ovf, proto_err
// -----------------------------------------------------------------------------
module dot_chunk_accumulator
   import dot_pkg::*;
#(
   parameter int PSUM_W     = DOT_PSUM_W,
   parameter int ACC_W      = DOT_ACC_W,
   parameter int IN_LAT     = DOT6_LAT,
   parameter int FIFO_DEPTH = DOT_FIFO_DEPTH
)(
   input  logic                   clk,
   input  logic                   rst_n,
   dot_chunk_accumulator_if.slave bus
);

   localparam int RESV_W = $clog2(FIFO_DEPTH + 1);
   localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
   localparam int RES_W  = ACC_W + 1;

   typedef struct packed {
      logic signed [ACC_W-1:0] acc;
      logic                    ovf;
   } res_t;

   // Sideband pipe; r_sb[IN_LAT-1] is aligned with psum.
   dot_sb_t                 r_sb [IN_LAT];
   dot_sb_t                 w_tail;

   acc_state_t              r_state;
   logic signed [ACC_W-1:0] r_acc;
   logic                    r_ovf;
   logic                    r_proto_err;
   logic                    r_issue_ready;
   logic [RESV_W-1:0]       r_resv;

   logic signed [ACC_W-1:0] w_psum_ext;
   logic signed [ACC_W-1:0] w_sum;
   logic signed [ACC_W-1:0] w_acc_next;
   logic                    w_ovf_next;
   logic                    w_start;
   logic                    w_push;
   logic                    w_err;
   logic                    w_inc;
   logic                    w_dec;
   logic [RESV_W-1:0]       w_resv_next;

   res_t                    w_push_res;
   res_t                    w_head;
   logic                    w_fifo_valid;
   logic                    w_fifo_full;
   logic [CNT_W-1:0]        w_fifo_count;

   // ---------------------------------------------------------------- sideband
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < IN_LAT; i++) begin
            r_sb[i] <= '0;
         end
      end else begin
         r_sb[0] <= '{v: bus.issue_valid,
                      f: bus.issue_valid & bus.issue_first,
                      l: bus.issue_valid & bus.issue_last};
         for (int i = 1; i < IN_LAT; i++) begin
            r_sb[i] <= r_sb[i-1];
         end
      end
   end

   assign w_tail     = r_sb[IN_LAT-1];
   assign w_psum_ext = ACC_W'(bus.psum);   // sign-extends: psum is signed
   assign w_sum      = r_acc + w_psum_ext; // wraps at ACC_W

   // ------------------------------------------------------------- accumulate
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned and no latch is inferred.
      w_start    = 1'b0;
      w_acc_next = r_acc;
      w_ovf_next = r_ovf;
      w_push     = 1'b0;
      w_err      = 1'b0;

      if (w_tail.v) begin
         // A stray middle chunk while idle restarts the sum like a first chunk.
         w_start = w_tail.f || (r_state == ACC_IDLE);
         if (w_start) begin
            w_acc_next = w_psum_ext;
            w_ovf_next = 1'b0;
         end else begin
            w_acc_next = w_sum;
            w_ovf_next = r_ovf | add_ovf(r_acc[ACC_W-1], w_psum_ext[ACC_W-1],
                                         w_sum[ACC_W-1]);
         end
         w_push = w_tail.l;
         w_err  = (w_tail.f && (r_state == ACC_BUSY)) ||
                  (!w_tail.f && (r_state == ACC_IDLE));
      end

      // Issuing without credit, or a result lost to a full FIFO.
      if ((bus.issue_valid && !r_issue_ready) ||
          (w_push && w_fifo_full && !bus.out_ready)) begin
         w_err = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ACC_IDLE;
         r_acc       <= '0;
         r_ovf       <= 1'b0;
         r_proto_err <= 1'b0;
      end else begin
         if (w_tail.v) begin
            r_acc   <= w_acc_next;
            r_ovf   <= w_ovf_next;
            r_state <= w_tail.l ? ACC_IDLE : ACC_BUSY;
         end
         if (w_err) begin
            r_proto_err <= 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------ credit
   assign w_inc = bus.issue_valid & bus.issue_last;
   assign w_dec = w_fifo_valid & bus.out_ready;

   always_comb begin
      w_resv_next = r_resv;
      case ({w_inc, w_dec})
         2'b10: if (r_resv != RESV_W'(FIFO_DEPTH)) w_resv_next = r_resv + RESV_W'(1);
         2'b01: if (r_resv != '0)                  w_resv_next = r_resv - RESV_W'(1);
         default: w_resv_next = r_resv;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_resv        <= '0;
         r_issue_ready <= 1'b0;
      end else begin
         r_resv        <= w_resv_next;
         r_issue_ready <= (w_resv_next < RESV_W'(FIFO_DEPTH));
      end
   end

   // ------------------------------------------------------------ result FIFO
   assign w_push_res = '{acc: w_acc_next, ovf: w_ovf_next};
   assign w_fifo_full = (w_fifo_count == CNT_W'(FIFO_DEPTH));

   dot_result_fifo #(
      .W     (RES_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_din   (w_push_res),
      .i_pop   (bus.out_ready),
      .o_valid (w_fifo_valid),
      .o_dout  (w_head),
      .o_count (w_fifo_count)
   );

   assign bus.issue_ready = r_issue_ready;
   assign bus.out_valid   = w_fifo_valid;
   assign bus.out_data    = w_head.acc;
   assign bus.out_ovf     = w_head.ovf;
   assign bus.proto_err   = r_proto_err;

endmodule

// File: tb/tb_dot_chunk_accumulator.sv
// -----------------------------------------------------------------------------
// tb_dot_chunk_accumulator
// Directed bench for dot_chunk_accumulator. A default build (ACC_W=32) and an
// ACC_W=18 build receive identical stimulus; a behavioural IN_LAT-deep
// pipeline stands in for the DSP chain so each chunk's psum reaches the DUT
// aligned with its sideband. Inputs change and outputs are sampled on the
// falling clock edge.
// -----------------------------------------------------------------------------
module tb_dot_chunk_accumulator;

   localparam int PSUM_W = 18;
   localparam int IN_LAT = 4;
   localparam int DEPTH  = 4;
   localparam int BOUND  = 20;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   logic signed [PSUM_W-1:0] op_psum;
   logic signed [PSUM_W-1:0] dsp_pipe [IN_LAT];

   dot_chunk_accumulator_if #(.PSUM_W(PSUM_W), .ACC_W(32)) bus   ();
   dot_chunk_accumulator_if #(.PSUM_W(PSUM_W), .ACC_W(18)) bus18 ();

   dot_chunk_accumulator #(
      .PSUM_W(PSUM_W), .ACC_W(32), .IN_LAT(IN_LAT), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   dot_chunk_accumulator #(
      .PSUM_W(PSUM_W), .ACC_W(18), .IN_LAT(IN_LAT), .FIFO_DEPTH(DEPTH)
   ) dut18 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus18)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // DSP chain stand-in: psum appears IN_LAT clocks after its operands.
   always_ff @(posedge clk) begin
      dsp_pipe[0] <= op_psum;
      for (int i = 1; i < IN_LAT; i++) begin
         dsp_pipe[i] <= dsp_pipe[i-1];
      end
   end

   assign bus.psum          = dsp_pipe[IN_LAT-1];
   assign bus18.psum        = dsp_pipe[IN_LAT-1];
   assign bus18.issue_valid = bus.issue_valid;
   assign bus18.issue_first = bus.issue_first;
   assign bus18.issue_last  = bus.issue_last;
   assign bus18.out_ready   = bus.out_ready;

   task automatic check(input string tag, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic issue_chunk(input logic f, input logic l, input int ps);
      bus.issue_valid = 1'b1;
      bus.issue_first = f;
      bus.issue_last  = l;
      op_psum         = PSUM_W'(ps);
      tick();
      bus.issue_valid = 1'b0;
      bus.issue_first = 1'b0;
      bus.issue_last  = 1'b0;
      op_psum         = '0;
   endtask

   task automatic pop_one();
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (!bus.out_valid && n < BOUND) begin
         tick();
         n++;
      end
   endtask

   int n;
   int k;
   int stale;
   longint exp_q [4];

   initial begin
      n_checks        = 0;
      n_fail          = 0;
      rst_n           = 1'b0;
      bus.issue_valid = 1'b0;
      bus.issue_first = 1'b0;
      bus.issue_last  = 1'b0;
      bus.out_ready   = 1'b0;
      op_psum         = '0;

      // ---- reset state
      repeat (5) tick();
      check("rst_out_valid",   bus.out_valid,   0);
      check("rst_issue_ready", bus.issue_ready, 0);
      check("rst_out_data",    bus.out_data,    0);
      check("rst_out_ovf",     bus.out_ovf,     0);
      check("rst_proto_err",   bus.proto_err,   0);
      rst_n = 1'b1;
      tick();
      check("rst_ready_after", bus.issue_ready, 1);

      // ---- 3-chunk vector 100 - 50 + 7 = 57, latency from last issue
      issue_chunk(1'b1, 1'b0, 100);
      issue_chunk(1'b0, 1'b0, -50);
      issue_chunk(1'b0, 1'b1, 7);
      wait_valid(n);
      check("v3_latency", n, IN_LAT);
      check("v3_data",    bus.out_data, 57);
      check("v3_ovf",     bus.out_ovf,  0);
      check("v3_data18",  bus18.out_data, 57);
      pop_one();
      check("v3_popped",  bus.out_valid, 0);

      // ---- single chunk, most negative psum is sign-extended
      issue_chunk(1'b1, 1'b1, -131072);
      wait_valid(n);
      check("neg_latency", n, IN_LAT);
      check("neg_data",    bus.out_data, -131072);
      check("neg_ovf",     bus.out_ovf,  0);
      pop_one();

      // ---- overflow at ACC_W=18 (wide build does not overflow)
      issue_chunk(1'b1, 1'b0, 131071);
      issue_chunk(1'b0, 1'b1, 1);
      wait_valid(n);
      check("ovf18_data",  bus18.out_data, -131072);
      check("ovf18_flag",  bus18.out_ovf,  1);
      check("ovf32_data",  bus.out_data,   131072);
      check("ovf32_flag",  bus.out_ovf,    0);
      pop_one();
      issue_chunk(1'b1, 1'b1, 5);
      wait_valid(n);
      check("ovf18_next_data", bus18.out_data, 5);
      check("ovf18_next_flag", bus18.out_ovf,  0);
      pop_one();

      // ---- credit throttling with consumer stalled
      issue_chunk(1'b1, 1'b1, 10);
      issue_chunk(1'b1, 1'b1, 20);
      issue_chunk(1'b1, 1'b1, 30);
      check("cr_ready_after3", bus.issue_ready, 1);
      issue_chunk(1'b1, 1'b1, 40);
      check("cr_ready_after4", bus.issue_ready, 0);
      repeat (IN_LAT + 2) tick();
      check("cr_ready_held",   bus.issue_ready, 0);
      check("cr_valid",        bus.out_valid,   1);
      check("cr_head0",        bus.out_data,    10);
      pop_one();
      check("cr_ready_back",   bus.issue_ready, 1);
      check("cr_head1",        bus.out_data,    20);
      issue_chunk(1'b1, 1'b1, 50);
      exp_q[0] = 20; exp_q[1] = 30; exp_q[2] = 40; exp_q[3] = 50;
      k = 0;
      bus.out_ready = 1'b1;
      for (int cyc = 0; cyc < 30 && k < 4; cyc++) begin
         if (bus.out_valid) begin
            check($sformatf("cr_order%0d", k), bus.out_data, exp_q[k]);
            k++;
         end
         tick();
      end
      bus.out_ready = 1'b0;
      check("cr_order_cnt",  k, 4);
      check("cr_proto_err",  bus.proto_err, 0);

      // ---- chunk without first while idle
      issue_chunk(1'b0, 1'b1, 77);
      wait_valid(n);
      check("pe_data",   bus.out_data,  77);
      check("pe_flag",   bus.proto_err, 1);
      pop_one();
      repeat (3) tick();
      check("pe_sticky", bus.proto_err, 1);

      // ---- reset with 2 FIFO entries and 2 chunks in flight
      issue_chunk(1'b1, 1'b1, 1);
      issue_chunk(1'b1, 1'b1, 2);
      repeat (IN_LAT + 1) tick();
      check("mr_fifo_filled", bus.out_valid, 1);
      issue_chunk(1'b1, 1'b0, 3);
      issue_chunk(1'b0, 1'b1, 4);
      rst_n = 1'b0;
      tick();
      check("mr_out_valid",   bus.out_valid,   0);
      check("mr_issue_ready", bus.issue_ready, 0);
      check("mr_proto_err",   bus.proto_err,   0);
      rst_n = 1'b1;
      tick();
      check("mr_ready_after", bus.issue_ready, 1);
      stale = 0;
      repeat (12) begin
         if (bus.out_valid) stale++;
         tick();
      end
      check("mr_no_stale",  stale, 0);
      check("mr_proto_low", bus.proto_err, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
